// File: rtl/snn_step_scheduler_pkg.sv
// rtl/snn_step_scheduler_pkg.sv - shared constants, LA bit map and FSM state type for the SNN step scheduler
package snn_pkg;
    localparam int N_NEURONS = 16;
    localparam int IDX_W     = 4;
    localparam int STEP_W    = 8;
    localparam int TIMEOUT   = 255;

    // Logic-analyzer bit map for the Caravel-side control word
    localparam int LA_START_BIT = 0;
    localparam int LA_ABORT_BIT = 1;
    localparam int LA_STEPS_LSB = 8;
    localparam int LA_STEPS_MSB = LA_STEPS_LSB + STEP_W - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_COMMIT
    } state_e;
endpackage

// File: rtl/snn_step_scheduler_if.sv
// rtl/snn_step_scheduler_if.sv - request/ack handshake between the scheduler and the neuron-update unit
interface snn_step_scheduler_if #(
    parameter int IDX_W = snn_pkg::IDX_W
);
    logic             nu_req;
    logic [IDX_W-1:0] nu_idx;
    logic             nu_spike;
    logic             nu_clear;
    logic             nu_ack;
    logic             nu_fire;

    modport master (
        output nu_req, nu_idx, nu_spike, nu_clear,
        input  nu_ack, nu_fire
    );

    modport slave (
        input  nu_req, nu_idx, nu_spike, nu_clear,
        output nu_ack, nu_fire
    );
endinterface

// File: rtl/snn_ack_timer.sv
// rtl/snn_ack_timer.sv - loadable down-counter that flags the cycle its count runs out
module snn_ack_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expire on the enabled cycle whose decrement lands on zero
    assign expire_o = en_i && (cnt_q <= W'(1));
endmodule

// File: rtl/snn_step_scheduler.sv
// rtl/snn_step_scheduler.sv - steps one shared LIF update unit across all neurons for a programmed number of time steps
module snn_step_scheduler
    import snn_pkg::*;
#(
    parameter int N_NEURONS = snn_pkg::N_NEURONS,
    parameter int IDX_W     = snn_pkg::IDX_W,
    parameter int STEP_W    = snn_pkg::STEP_W,
    parameter int TIMEOUT   = snn_pkg::TIMEOUT
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [STEP_W-1:0]       steps_i,
    input  logic [N_NEURONS-1:0]    spikes_in_i,
    snn_step_scheduler_if.master    nu,
    output logic [N_NEURONS-1:0]    spikes_out_o,
    output logic                    spikes_valid_o,
    output logic [STEP_W-1:0]       step_cnt_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_e                 state_q, state_d;
    logic                   start_q;
    logic [STEP_W-1:0]      steps_q;
    logic [STEP_W-1:0]      step_cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [N_NEURONS-1:0]   spk_q;
    logic [N_NEURONS-1:0]   acc_q;
    logic [N_NEURONS-1:0]   spikes_out_q;
    logic                   spikes_valid_q;
    logic                   done_q;
    logic                   err_q;

    logic                   start_edge;
    logic                   last_idx;
    logic [STEP_W-1:0]      step_cnt_inc;
    logic                   abort_run;
    logic                   tmr_expire;

    logic                   req;
    logic [IDX_W-1:0]       req_idx;
    logic                   req_spike;
    logic                   req_clear;

    assign start_edge   = start_i & ~start_q;
    assign last_idx     = (idx_q == IDX_W'(N_NEURONS - 1));
    assign step_cnt_inc = step_cnt_q + 1'b1;
    assign abort_run    = abort_i && (state_q != ST_IDLE);

    snn_ack_timer #(
        .W (TMR_W)
    ) u_ack_timer (
        .clk_i      (wb_clk_i),
        .rst_i      (wb_rst_i),
        .load_i     (state_q == ST_ISSUE),
        .load_val_i (TMR_W'(TIMEOUT)),
        .en_i       (state_q == ST_WAIT),
        .expire_o   (tmr_expire)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_edge && (steps_i != '0)) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD:  state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // A late ack still completes the handshake even on the expiring cycle
                if (nu.nu_ack) begin
                    state_d = last_idx ? ST_COMMIT : ST_ISSUE;
                end else if (tmr_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: state_d = (step_cnt_inc == steps_q) ? ST_IDLE : ST_LOAD;
            default:   state_d = ST_IDLE;
        endcase
        if (abort_run) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        req       = 1'b0;
        req_idx   = '0;
        req_spike = 1'b0;
        req_clear = 1'b0;
        if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) begin
            req       = 1'b1;
            req_idx   = idx_q;
            req_spike = spk_q[idx_q];
            req_clear = (step_cnt_q == '0);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            start_q        <= 1'b0;
            steps_q        <= '0;
            step_cnt_q     <= '0;
            idx_q          <= '0;
            spk_q          <= '0;
            acc_q          <= '0;
            spikes_out_q   <= '0;
            spikes_valid_q <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            start_q        <= start_i;
            spikes_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        steps_q    <= steps_i;
                        step_cnt_q <= '0;
                        done_q     <= (steps_i == '0);
                        err_q      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    spk_q <= spikes_in_i;
                    idx_q <= '0;
                    acc_q <= '0;
                end
                ST_WAIT: begin
                    if (!abort_run) begin
                        if (nu.nu_ack) begin
                            acc_q[idx_q] <= nu.nu_fire;
                            if (!last_idx) begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end else if (tmr_expire) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (!abort_run) begin
                        spikes_out_q   <= acc_q;
                        spikes_valid_q <= 1'b1;
                        step_cnt_q     <= step_cnt_inc;
                        if (step_cnt_inc == steps_q) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign nu.nu_req      = req;
    assign nu.nu_idx      = req_idx;
    assign nu.nu_spike    = req_spike;
    assign nu.nu_clear    = req_clear;

    assign spikes_out_o   = spikes_out_q;
    assign spikes_valid_o = spikes_valid_q;
    assign step_cnt_o     = step_cnt_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = done_q;
    assign err_o          = err_q;
endmodule

// File: doc/snn_step_scheduler.md
Name: snn_step_scheduler

Overview:
- Sequences one shared LIF neuron-update datapath across all neurons of the SNN accelerator, one neuron per handshake, for a programmed number of time steps.
- Sits between the Caravel-facing control (logic-analyzer bits for start/abort/step count, IO pads for input spikes) and the neuron-update unit.
- Collects per-step output spike vectors and reports progress, completion and handshake errors.

Parameters:
- N_NEURONS, 16, neurons per time step; also the spike vector width.
- IDX_W, 4, neuron index width; equals clog2(N_NEURONS).
- STEP_W, 8, width of the step count and step counter.
- TIMEOUT, 255, maximum cycles to wait for nu_ack_i before flagging an error.

Ports:
- wb_clk_i, in, 1: system clock.
- wb_rst_i, in, 1: reset, synchronous, active-high.
- start_i, in, 1: run request level from LA; the rising edge is detected internally.
- abort_i, in, 1: level; stops the run at the next cycle.
- steps_i, in, STEP_W: number of time steps, sampled on the start edge.
- spikes_in_i, in, N_NEURONS: input spike vector, sampled once per step.
- nu_req_o, out, 1: update request to the neuron unit.
- nu_idx_o, out, IDX_W: neuron index for the request.
- nu_spike_o, out, 1: input spike bit for that neuron.
- nu_clear_o, out, 1: high during step 0 requests; the unit zeroes the membrane before integrating.
- nu_ack_i, in, 1: update accepted and complete.
- nu_fire_i, in, 1: neuron fired; valid only in the nu_ack_i cycle.
- spikes_out_o, out, N_NEURONS: output spikes of the last completed step.
- spikes_valid_o, out, 1: one-cycle pulse when spikes_out_o updates.
- step_cnt_o, out, STEP_W: number of completed steps in the current run.
- busy_o, out, 1: high in any state except IDLE.
- done_o, out, 1: sticky; set at normal completion, cleared by the next accepted start.
- err_o, out, 1: sticky; set on timeout, cleared by the next accepted start.

Behaviour:
- Clock and reset:
  - Single clock wb_clk_i.
  - wb_rst_i is synchronous and active-high.
  - On reset all outputs are 0, the FSM is in IDLE, and the start edge detector's previous-value register is 0.
- Start edge: start_edge = start_i & ~start_q. It is accepted only in IDLE and ignored otherwise.
- FSM states: IDLE, LOAD, ISSUE, WAIT, COMMIT.
- IDLE:
  - On start_edge, latch steps_i into steps_r, clear step_cnt_o, done_o and err_o.
  - If steps_i == 0, set done_o and stay in IDLE. busy_o never rises and nu_req_o is never asserted.
  - Otherwise go to LOAD.
- LOAD:
  - Capture spikes_in_i into spk_r, set idx = 0, clear the fire accumulator.
  - Go to ISSUE.
- ISSUE:
  - Drive nu_req_o = 1, nu_idx_o = idx, nu_spike_o = spk_r[idx], nu_clear_o = (step_cnt_o == 0).
  - Load the timeout counter with TIMEOUT and go to WAIT.
  - The first request appears 2 cycles after the start edge cycle.
- WAIT:
  - nu_req_o and all request fields stay held stable until nu_ack_i = 1 is sampled.
  - On ack: acc[idx] <= nu_fire_i and nu_req_o drops. If idx == N_NEURONS-1 go to COMMIT, else idx+1 and go to ISSUE.
  - An ack while nu_req_o = 0 (in any state) is ignored.
  - Without an ack the counter decrements each cycle. If it reaches 0 with no ack, set err_o, drop nu_req_o and go to IDLE. spikes_out_o is not updated.
- Throughput: at most one request per 2 cycles (ISSUE, then WAIT).
- COMMIT:
  - spikes_out_o <= acc, pulse spikes_valid_o for 1 cycle, step_cnt_o + 1.
  - If the new count == steps_r, set done_o and go to IDLE; else go to LOAD.
- Abort:
  - abort_i = 1 in any non-IDLE state means IDLE next cycle.
  - nu_req_o drops, done_o is not set, and the partial step is discarded.
  - If abort_i and nu_ack_i coincide, abort wins and the fire bit is dropped.
  - Abort in IDLE has no effect.
- Simultaneous timeout and ack in the same cycle: the ack wins.
- step_cnt_o saturates naturally at steps_r; with steps_i = 255 there is no wrap.
- Reset mid-run: immediate return to reset values; the neuron unit must tolerate a request dropping.

Decomposition:
- Shared package snn_pkg holds:
  - the state enum;
  - constants N_NEURONS, IDX_W, STEP_W, TIMEOUT defaults;
  - the LA bit map for start/abort/steps.
- One natural sub-module is snn_ack_timer: a loadable down-counter with an expire flag, reusable by other handshake masters.
- The FSM and the accumulator stay in snn_step_scheduler.

Test Plan:
- Normal run:
  - Stimulus: steps_i = 2, spikes_in_i = 16'h00FF; the unit acks 1 cycle after req and fires on odd idx.
  - Expected: 32 requests; nu_clear_o high for the first 16 only; two spikes_valid_o pulses, each with spikes_out_o = 16'hAAAA.
  - Expected: step_cnt_o = 2, done_o = 1, busy_o = 0.
- Zero-length run:
  - Stimulus: steps_i = 0 with a start edge.
  - Expected: done_o = 1 the next cycle; nu_req_o never asserted; busy_o stays 0.
- Ack stall:
  - Stimulus: hold nu_ack_i low for 10 cycles on idx 5.
  - Expected: nu_idx_o = 5 and nu_spike_o stay stable throughout; the run completes normally with err_o = 0.
- Timeout:
  - Stimulus: never ack idx 3.
  - Expected: err_o = 1 exactly TIMEOUT cycles after WAIT entry; FSM in IDLE; done_o = 0; no spikes_valid_o pulse.
  - Expected: the next start edge clears err_o.
- Abort:
  - Stimulus: assert abort_i in the same cycle as the ack for idx 7 of step 1.
  - Expected: IDLE next cycle, step_cnt_o = 1, done_o = 0.
  - Expected: a start edge during busy_o is ignored, and a held start_i does not retrigger.
- Reset mid-run:
  - Stimulus: assert wb_rst_i while in WAIT.
  - Expected: the next cycle all outputs are 0 and the FSM is in IDLE.
